// File: rtl/nibble_mayor_ventana.sv
// Frame-maximum tracker: groups accepted nibbles into frames, reports the max, its first index and length.
// Optional tie counter built when NIBBLE_VENTANA_TIES_EN is defined; otherwise out_ties is constant 0.
module nibble_mayor_ventana #(
    parameter int FRAME_LEN = 8,
    parameter int IDX_W     = 3
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    input  logic [3:0]       in_nibble,
    input  logic             frame_flush,
    output logic             in_ready,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [3:0]       out_max,
    output logic [IDX_W-1:0] out_idx,
    output logic [IDX_W:0]   out_len,
    output logic [IDX_W:0]   out_ties
);

    typedef enum logic {
        ACUM    = 1'b0,
        ENTREGA = 1'b1
    } state_t;

    localparam logic [IDX_W:0] CNT_ONE  = (IDX_W + 1)'(1);
    localparam logic [IDX_W:0] CNT_LAST = (IDX_W + 1)'(FRAME_LEN - 1);

    state_t            state;
    state_t            state_next;
    logic [IDX_W:0]    count;
    logic [3:0]        acc_max;
    logic [IDX_W-1:0]  acc_idx;

    logic              accept;
    logic              close;
    logic              take;
    logic [IDX_W:0]    count_inc;
    logic [IDX_W:0]    len_final;
    logic [3:0]        max_next;
    logic [IDX_W-1:0]  idx_next;

    logic [3:0]        out_max_q;
    logic [IDX_W-1:0]  out_idx_q;
    logic [IDX_W:0]    out_len_q;

`ifdef NIBBLE_VENTANA_TIES_EN
    logic [IDX_W:0]    acc_ties;
    logic [IDX_W:0]    ties_next;
    logic [IDX_W:0]    out_ties_q;
`endif

    // Handshake flags come from the state register; reset only masks them while held low.
    assign in_ready  = (state == ACUM) && reset;
    assign out_valid = (state == ENTREGA) && reset;
    assign accept    = in_valid && in_ready;
    assign take      = out_valid && out_ready;
    assign count_inc = count + CNT_ONE;

    // NOTE: every signal written here gets a default first so no latch can be inferred.
    always_comb begin
        max_next   = acc_max;
        idx_next   = acc_idx;
`ifdef NIBBLE_VENTANA_TIES_EN
        ties_next  = acc_ties;
`endif
        close      = 1'b0;
        len_final  = count;
        state_next = state;

        if (accept) begin
            len_final = count_inc;
            if (count == '0) begin
                max_next = in_nibble;
                idx_next = '0;
`ifdef NIBBLE_VENTANA_TIES_EN
                ties_next = CNT_ONE;
`endif
            end else if (in_nibble > acc_max) begin
                max_next = in_nibble;
                idx_next = count[IDX_W-1:0];
`ifdef NIBBLE_VENTANA_TIES_EN
                ties_next = CNT_ONE;
`endif
            end else if (in_nibble == acc_max) begin
`ifdef NIBBLE_VENTANA_TIES_EN
                ties_next = acc_ties + CNT_ONE;
`endif
            end
        end

        unique case (state)
            ACUM: begin
                if (accept)
                    close = (count == CNT_LAST) || frame_flush;
                else
                    close = frame_flush && (count != '0) && reset;
                if (close)
                    state_next = ENTREGA;
            end
            ENTREGA: begin
                if (take)
                    state_next = ACUM;
            end
            default: state_next = ACUM;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= ACUM;
            count     <= '0;
            acc_max   <= '0;
            acc_idx   <= '0;
            out_max_q <= '0;
            out_idx_q <= '0;
            out_len_q <= '0;
`ifdef NIBBLE_VENTANA_TIES_EN
            acc_ties   <= '0;
            out_ties_q <= '0;
`endif
        end else begin
            state <= state_next;

            if (accept)
                count <= count_inc;
            else if (take)
                count <= '0;

            if (accept) begin
                acc_max <= max_next;
                acc_idx <= idx_next;
`ifdef NIBBLE_VENTANA_TIES_EN
                acc_ties <= ties_next;
`endif
            end

            // Results persist after the handoff until the next frame closes.
            if (close) begin
                out_max_q <= max_next;
                out_idx_q <= idx_next;
                out_len_q <= len_final;
`ifdef NIBBLE_VENTANA_TIES_EN
                out_ties_q <= ties_next;
`endif
            end
        end
    end

    assign out_max = out_max_q;
    assign out_idx = out_idx_q;
    assign out_len = out_len_q;

`ifdef NIBBLE_VENTANA_TIES_EN
    assign out_ties = out_ties_q;
`else
    assign out_ties = '0;
`endif

endmodule

// File: tb/tb_nibble_mayor_ventana.sv
// Directed bench for nibble_mayor_ventana (FRAME_LEN=8, IDX_W=3); expected values computed by hand.
module tb_nibble_mayor_ventana;

    logic       clk;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_nibble;
    logic       frame_flush;
    logic       in_ready;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_max;
    logic [2:0] out_idx;
    logic [3:0] out_len;
    logic [3:0] out_ties;

    int checks = 0;
    int errors = 0;

    nibble_mayor_ventana #(.FRAME_LEN(8), .IDX_W(3)) dut (
        .clk         (clk),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_nibble   (in_nibble),
        .frame_flush (frame_flush),
        .in_ready    (in_ready),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_max     (out_max),
        .out_idx     (out_idx),
        .out_len     (out_len),
        .out_ties    (out_ties)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] exp_ties(input int n);
`ifdef NIBBLE_VENTANA_TIES_EN
        return 32'(n);
`else
        return 32'(0 * n);
`endif
    endfunction

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    // Advance one edge and settle 1 time unit past it before sampling.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [3:0] nib, input logic flush);
        in_valid    = 1'b1;
        in_nibble   = nib;
        frame_flush = flush;
        step();
        in_valid    = 1'b0;
        frame_flush = 1'b0;
    endtask

    task automatic check_result(input string tag, input int mx, input int idx, input int len, input int ties);
        check({tag, "_valid"}, 32'(out_valid), 32'd1);
        check({tag, "_max"},   32'(out_max),   32'(mx));
        check({tag, "_idx"},   32'(out_idx),   32'(idx));
        check({tag, "_len"},   32'(out_len),   32'(len));
        check({tag, "_ties"},  32'(out_ties),  exp_ties(ties));
        check({tag, "_rdy"},   32'(in_ready),  32'd0);
    endtask

    task automatic handoff(input string tag);
        out_ready = 1'b1;
        step();
        out_ready = 1'b0;
        check({tag, "_taken"}, 32'(out_valid), 32'd0);
        check({tag, "_rdy1"},  32'(in_ready),  32'd1);
    endtask

    initial begin
        reset       = 1'b0;
        in_valid    = 1'b0;
        in_nibble   = 4'h0;
        frame_flush = 1'b0;
        out_ready   = 1'b0;

        // Reset values
        repeat (3) step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_ready", 32'(in_ready),  32'd0);
        check("rst_max",   32'(out_max),   32'd0);
        check("rst_idx",   32'(out_idx),   32'd0);
        check("rst_len",   32'(out_len),   32'd0);
        check("rst_ties",  32'(out_ties),  32'd0);
        reset = 1'b1;
        #1;
        check("post_rst_ready", 32'(in_ready), 32'd1);

        // Full frame 3,7,2,7,1,0,5,6
        send(4'd3, 1'b0); send(4'd7, 1'b0); send(4'd2, 1'b0); send(4'd7, 1'b0);
        send(4'd1, 1'b0); send(4'd0, 1'b0); send(4'd5, 1'b0);
        check("full_not_yet", 32'(out_valid), 32'd0);
        send(4'd6, 1'b0);
        check_result("full", 7, 1, 8, 2);

        // Backpressure: samples offered while in_ready=0 must be dropped
        for (int i = 0; i < 5; i++) begin
            in_valid  = 1'b1;
            in_nibble = 4'hF;
            step();
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_max",   32'(out_max),   32'd7);
            check("bp_len",   32'(out_len),   32'd8);
            check("bp_ready", 32'(in_ready),  32'd0);
        end
        in_valid = 1'b0;
        handoff("bp");
        check("bp_hold_max", 32'(out_max), 32'd7);

        // Early flush on the 3rd sample
        send(4'd4, 1'b0); send(4'd9, 1'b0); send(4'd9, 1'b1);
        check_result("flush", 9, 1, 3, 2);
        handoff("flush");

        // Flush with no sample after two samples
        send(4'd1, 1'b0); send(4'd2, 1'b0);
        check("nsf_pending", 32'(out_valid), 32'd0);
        frame_flush = 1'b1;
        step();
        frame_flush = 1'b0;
        check_result("nsf", 2, 1, 2, 1);
        handoff("nsf");

        // Flush at count 0 is ignored
        frame_flush = 1'b1;
        step();
        frame_flush = 1'b0;
        check("empty_flush0", 32'(out_valid), 32'd0);
        step();
        check("empty_flush1", 32'(out_valid), 32'd0);

        // Reset mid-frame discards the partial frame
        for (int i = 0; i < 5; i++) send(4'd9, 1'b0);
        reset = 1'b0;
        step();
        check("midrst_valid", 32'(out_valid), 32'd0);
        check("midrst_max",   32'(out_max),   32'd0);
        check("midrst_len",   32'(out_len),   32'd0);
        reset = 1'b1;
        for (int i = 0; i < 7; i++) send(4'hF, 1'b0);
        check("allf_not_yet", 32'(out_valid), 32'd0);
        send(4'hF, 1'b0);
        check_result("allf", 15, 0, 8, 8);
        handoff("allf");

        // All zeros
        for (int i = 0; i < 8; i++) send(4'd0, 1'b0);
        check_result("zero", 0, 0, 8, 8);
        handoff("zero");

        // Ascending 0..7 with out_ready held high beforehand
        out_ready = 1'b1;
        for (int i = 0; i < 7; i++) send(4'(i), 1'b0);
        check("asc_early_ready", 32'(out_valid), 32'd0);
        send(4'd7, 1'b0);
        check("asc_valid", 32'(out_valid), 32'd1);
        check("asc_max",   32'(out_max),   32'd7);
        check("asc_idx",   32'(out_idx),   32'd7);
        check("asc_len",   32'(out_len),   32'd8);
        check("asc_ties",  32'(out_ties),  exp_ties(1));
        step();
        out_ready = 1'b0;
        check("asc_taken", 32'(out_valid), 32'd0);
        check("asc_rdy1",  32'(in_ready),  32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
